// File: rtl/bk_pkg.sv
// rtl/bk_pkg.sv - shared width, prefix-tree types and the generate/propagate combine operator
package bk_pkg;

  localparam int BK_W = 16;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  // Everything the down-sweep needs, captured at the stage-1 register.
  typedef struct packed {
    pg_t [15:0] bit_pg;
    pg_t [7:0]  pair;
    pg_t        g3_0;
    pg_t        g7_4;
    pg_t        g7_0;
    pg_t        g11_8;
    pg_t        g15_8;
    pg_t        g15_0;
  } up_t;

  function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/bk_prefix16_split.sv
// rtl/bk_prefix16_split.sv - 16-bit Brent-Kung prefix tree for a + ~b + 1, split into up-sweep and down-sweep
module bk_prefix16_split
  import bk_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output up_t         up,
  input  up_t         st,
  output logic [15:0] diff,
  output logic        cout
);

  logic [15:0] bb;
  logic [15:0] c;
  pg_t         g11_0;
  pg_t         g13_0;
  pg_t         g5_0;
  pg_t         g9_0;
  logic        unused_st;

  assign bb = ~b;

  always_comb begin
    up = '0;
    for (int i = 0; i < 16; i++) begin
      up.bit_pg[i].p = a[i] ^ bb[i];
      up.bit_pg[i].g = a[i] & bb[i];
    end
    // The subtract carry-in of 1 is absorbed into bit 0's generate.
    up.bit_pg[0].g = (a[0] & bb[0]) | (a[0] ^ bb[0]);
    for (int k = 0; k < 8; k++) begin
      up.pair[k] = pg_combine(up.bit_pg[2*k+1], up.bit_pg[2*k]);
    end
    up.g3_0  = pg_combine(up.pair[1], up.pair[0]);
    up.g7_4  = pg_combine(up.pair[3], up.pair[2]);
    up.g7_0  = pg_combine(up.g7_4, up.g3_0);
    up.g11_8 = pg_combine(up.pair[5], up.pair[4]);
    up.g15_8 = pg_combine(pg_combine(up.pair[7], up.pair[6]), up.g11_8);
    up.g15_0 = pg_combine(up.g15_8, up.g7_0);
  end

  assign g5_0  = pg_combine(st.pair[2], st.g3_0);
  assign g9_0  = pg_combine(st.pair[4], st.g7_0);
  assign g11_0 = pg_combine(st.g11_8, st.g7_0);
  assign g13_0 = pg_combine(st.pair[6], g11_0);

  always_comb begin
    c     = '0;
    c[0]  = 1'b1;
    c[1]  = st.bit_pg[0].g;
    c[2]  = st.pair[0].g;
    c[3]  = pg_combine(st.bit_pg[2], st.pair[0]).g;
    c[4]  = st.g3_0.g;
    c[5]  = pg_combine(st.bit_pg[4], st.g3_0).g;
    c[6]  = g5_0.g;
    c[7]  = pg_combine(st.bit_pg[6], g5_0).g;
    c[8]  = st.g7_0.g;
    c[9]  = pg_combine(st.bit_pg[8], st.g7_0).g;
    c[10] = g9_0.g;
    c[11] = pg_combine(st.bit_pg[10], g9_0).g;
    c[12] = g11_0.g;
    c[13] = pg_combine(st.bit_pg[12], g11_0).g;
    c[14] = g13_0.g;
    c[15] = pg_combine(st.bit_pg[14], g13_0).g;
    for (int i = 0; i < 16; i++) begin
      diff[i] = st.bit_pg[i].p ^ c[i];
    end
  end

  assign cout = st.g15_0.g;

  // Up-sweep terms that only feed higher groups, never a bit carry.
  assign unused_st = ^{st.pair[1], st.pair[3], st.pair[5], st.pair[7], st.g7_4, st.g15_8,
                       st.g15_0.p, st.bit_pg[1].g, st.bit_pg[3].g, st.bit_pg[5].g,
                       st.bit_pg[7].g, st.bit_pg[9].g, st.bit_pg[11].g, st.bit_pg[13].g,
                       st.bit_pg[15].g};

endmodule

// File: rtl/bk_subtractor_pipe.sv
// rtl/bk_subtractor_pipe.sv - two-stage valid/ready pipelined 16-bit subtractor with borrow/ovf/zero flags
module bk_subtractor_pipe
  import bk_pkg::*;
#(
  parameter int WIDTH = BK_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  generate
    if (WIDTH != BK_W) begin : g_bad_width
      $error("bk_subtractor_pipe: WIDTH must be %0d", BK_W);
    end
  endgenerate

  up_t             up_c;
  up_t             s1_up;
  logic            s1_v;
  logic            s1_a_msb;
  logic            s1_b_msb;
  logic            s2_v;
  logic [WIDTH-1:0] diff_c;
  logic            cout_c;
  logic            ovf_c;
  logic            s1_go;
  logic            s2_go;
  logic            accept;

  bk_prefix16_split u_prefix (
    .a    (a),
    .b    (b),
    .up   (up_c),
    .st   (s1_up),
    .diff (diff_c),
    .cout (cout_c)
  );

  assign s2_go     = !s2_v || out_ready;
  assign s1_go     = s1_v && s2_go;
  // Held low during reset so nothing is offered an accept it would lose.
  assign in_ready  = !rst && (!s1_v || s2_go);
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_v;
  assign ovf_c     = (s1_a_msb ^ s1_b_msb) & (s1_a_msb ^ diff_c[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s1_up    <= '0;
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_v <= in_valid;
      end
      if (accept) begin
        s1_up    <= up_c;
        s1_a_msb <= a[WIDTH-1];
        s1_b_msb <= b[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      if (s2_go) begin
        s2_v <= s1_v;
      end
      if (s1_go) begin
        diff   <= diff_c;
        borrow <= ~cout_c;
        ovf    <= ovf_c;
        zero   <= (diff_c == '0);
      end
    end
  end

endmodule

// File: tb/tb_bk_subtractor_pipe.sv
// tb/tb_bk_subtractor_pipe.sv - randomized and directed self-checking bench for bk_subtractor_pipe
module tb_bk_subtractor_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        borrow;
  logic        ovf;
  logic        zero;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [18:0] exp_q[$];

  bk_subtractor_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Golden result packed as {diff, borrow, ovf, zero}, from integer arithmetic.
  function automatic logic [18:0] ref_sub(input logic [15:0] x, input logic [15:0] y);
    int sx, sy, sd;
    logic [15:0] d;
    sx = $signed(x);
    sy = $signed(y);
    sd = sx - sy;
    d  = x - y;
    return {d, (x < y), (sd > 32767 || sd < -32768), (d == 16'd0)};
  endfunction

  // One clock: drive at the falling edge, observe 1ns later, log accepted inputs.
  task automatic cycle(input logic v, input logic [15:0] av, input logic [15:0] bv, input logic ordy,
                       output logic acc, output logic took, output logic [18:0] got);
    @(negedge clk);
    in_valid  = v;
    a         = av;
    b         = bv;
    out_ready = ordy;
    #1;
    acc  = in_valid && in_ready;
    took = out_valid && out_ready;
    got  = {diff, borrow, ovf, zero};
    if (acc) exp_q.push_back(ref_sub(av, bv));
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b need 0", in_ready); end
    n_cmp++; if ({diff, borrow, ovf, zero} !== 19'd0) begin n_bad++; $display("FAIL reset_outputs: got %h need 0", {diff, borrow, ovf, zero}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %b need 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [15:0] va[6] = '{16'h0005, 16'h0000, 16'h8000, 16'h1234, 16'h7FFF, 16'h8000};
    logic [15:0] vb[6] = '{16'h0003, 16'h0001, 16'h0001, 16'h1234, 16'hFFFF, 16'h0000};
    logic [18:0] ve[6] = '{{16'h0002, 3'b000}, {16'hFFFF, 3'b100}, {16'h7FFF, 3'b010},
                           {16'h0000, 3'b001}, {16'h8000, 3'b110}, {16'h8000, 3'b000}};
    logic acc, took;
    logic [18:0] got;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, va[i], vb[i], 1'b1, acc, took, got);
      n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL directed_accept[%0d]: got %b need 1", i, acc); end
      cycle(1'b0, 16'h0, 16'h0, 1'b1, acc, took, got);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL directed_early[%0d]: out_valid %b need 0", i, out_valid); end
      if (took && exp_q.size() > 0) void'(exp_q.pop_front());
      cycle(1'b0, 16'h0, 16'h0, 1'b1, acc, took, got);
      n_cmp++;
      if (!took || got !== ve[i]) begin
        n_bad++; $display("FAIL directed_result[%0d]: valid %b got %h need %h", i, took, got, ve[i]);
      end
      if (took && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] av[4], bv[4];
    logic acc, took, held_ok;
    logic [18:0] got, held, want;
    int sent, got_n, idx;
    sent = 0; got_n = 0; held_ok = 1'b0; held = '0;
    for (int i = 0; i < 4; i++) begin av[i] = 16'($urandom); bv[i] = 16'($urandom); end
    for (int cyc = 0; cyc < 6; cyc++) begin
      idx = (sent < 4) ? sent : 0;
      cycle(sent < 4, av[idx], bv[idx], 1'b0, acc, took, got);
      if (acc) sent++;
      if (out_valid) begin
        if (held_ok) begin
          n_cmp++; if (got !== held) begin n_bad++; $display("FAIL stall_hold: got %h need %h", got, held); end
        end
        held = got; held_ok = 1'b1;
      end
    end
    n_cmp++; if (sent !== 2) begin n_bad++; $display("FAIL stall_accepts: got %0d need 2", sent); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %b need 0", in_ready); end
    for (int cyc = 0; cyc < 30 && got_n < 4; cyc++) begin
      idx = (sent < 4) ? sent : 0;
      cycle(sent < 4, av[idx], bv[idx], 1'b1, acc, took, got);
      if (acc) sent++;
      if (took) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h7FFFF;
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL drain_order[%0d]: got %h need %h", got_n, got, want); end
        got_n++;
      end
    end
    n_cmp++; if (got_n !== 4) begin n_bad++; $display("FAIL drain_count: got %0d need 4", got_n); end
    for (int cyc = 0; cyc < 3; cyc++) begin
      cycle(1'b0, 16'h0, 16'h0, 1'b1, acc, took, got);
      n_cmp++; if (took !== 1'b0) begin n_bad++; $display("FAIL drain_duplicate: extra result %h", got); end
    end
  endtask

  task automatic test_reset_midflight();
    logic acc, took;
    logic [18:0] got, want;
    cycle(1'b1, 16'h0000, 16'h0001, 1'b0, acc, took, got);
    cycle(1'b1, 16'h4321, 16'h0123, 1'b0, acc, took, got);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b0, acc, took, got);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL async_rst_valid: got %b need 0", out_valid); end
    n_cmp++; if ({diff, borrow, ovf, zero} !== 19'd0) begin n_bad++; $display("FAIL async_rst_outputs: got %h need 0", {diff, borrow, ovf, zero}); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL async_rst_in_ready: got %b need 0", in_ready); end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_in_ready: got %b need 1", in_ready); end
    cycle(1'b1, 16'h0100, 16'h0200, 1'b1, acc, took, got);
    cycle(1'b0, 16'h0, 16'h0, 1'b1, acc, took, got);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_stale: out_valid %b need 0", out_valid); end
    cycle(1'b0, 16'h0, 16'h0, 1'b1, acc, took, got);
    want = ref_sub(16'h0100, 16'h0200);
    n_cmp++; if (!took || got !== want) begin n_bad++; $display("FAIL post_rst_result: valid %b got %h need %h", took, got, want); end
    if (took && exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic test_sweep();
    logic [15:0] corners[5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    logic [15:0] sa[$], sb[$];
    logic acc, took, prev_stall, v, ordy;
    logic [18:0] got, prev_got, want;
    int idx, bad_seen;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin sa.push_back(corners[i]); sb.push_back(corners[j]); end
    for (int i = 0; i < 3000; i++) begin sa.push_back(16'($urandom)); sb.push_back(16'($urandom)); end
    idx = 0; prev_stall = 1'b0; prev_got = '0; bad_seen = 0;
    for (int cyc = 0; cyc < 20000 && (idx < sa.size() || exp_q.size() > 0); cyc++) begin
      v    = (idx < sa.size()) && ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      cycle(v, v ? sa[idx] : 16'h0, v ? sb[idx] : 16'h0, ordy, acc, took, got);
      if (acc) idx++;
      if (prev_stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || got !== prev_got) begin
          n_bad++;
          if (bad_seen < 10) $display("FAIL sweep_hold: valid %b got %h need %h", out_valid, got, prev_got);
          bad_seen++;
        end
      end
      if (took) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h7FFFF;
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          if (bad_seen < 10) $display("FAIL sweep_result: got %h need %h", got, want);
          bad_seen++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_got   = got;
    end
    n_cmp++;
    if (idx != sa.size() || exp_q.size() != 0) begin
      n_bad++; $display("FAIL sweep_complete: sent %0d of %0d, %0d results outstanding", idx, sa.size(), exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
